// File: rtl/bounce_2d.sv
// ============================================================================
// bounce_2d : 2-D bouncing-ball position generator (gravity, walls, rest, kick)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module bounce_2d #(
    parameter int COORD_W    = 11,
    parameter int VEL_W      = 6,
    parameter int TICK_DIV   = 692640,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 1007,
    parameter int Y_MIN      = 0,
    parameter int Y_FLOOR    = 500,
    parameter int X_INIT     = 504,
    parameter int Y_INIT     = 0,
    parameter int VX         = 2,
    parameter int GRAVITY    = 1,
    parameter int DAMP_SHIFT = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               pause,
    input  logic               kick,
    input  logic [VEL_W-1:0]   kick_vel,
    output logic [COORD_W-1:0] center_x,
    output logic [COORD_W-1:0] center_y,
    output logic [VEL_W-1:0]   vel_y,
    output logic               dir_up,
    output logic               frame_tick,
    output logic               bounce,
    output logic               at_rest
);

    localparam int                  c_CNT_W   = $clog2(TICK_DIV);
    localparam logic [c_CNT_W-1:0]  c_LAST    = c_CNT_W'(TICK_DIV - 1);
    localparam logic [COORD_W:0]    c_YFLR_W  = (COORD_W + 1)'(Y_FLOOR);
    localparam logic [COORD_W:0]    c_XMAX_W  = (COORD_W + 1)'(X_MAX);
    localparam logic [COORD_W-1:0]  c_Y_FLOOR = COORD_W'(Y_FLOOR);
    localparam logic [COORD_W-1:0]  c_Y_MIN   = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0]  c_X_MIN   = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0]  c_X_MAX   = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0]  c_X_INIT  = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0]  c_Y_INIT  = COORD_W'(Y_INIT);
    localparam logic [COORD_W-1:0]  c_VX      = COORD_W'(VX);
    localparam logic [VEL_W:0]      c_GRAV_W  = (VEL_W + 1)'(GRAVITY);
    localparam logic [VEL_W-1:0]    c_GRAV    = VEL_W'(GRAVITY);

    logic [c_CNT_W-1:0] r_cnt;
    logic [COORD_W-1:0] r_x, r_y;
    logic [VEL_W-1:0]   r_vel, r_kvel;
    logic               r_up, r_left, r_rest, r_pend, r_ft, r_bounce;

    logic               w_upd, w_step, w_pend, w_xmove, w_vhit, w_hhit;
    logic [VEL_W-1:0]   w_kvel, w_vdamp, w_vsat;
    logic [VEL_W:0]     w_vinc;
    logic [COORD_W:0]   w_ysum, w_xsum;
    logic [COORD_W-1:0] w_ydist, w_xdist, w_vext;
    logic [COORD_W-1:0] w_x_nx, w_y_nx;
    logic [VEL_W-1:0]   w_v_nx;
    logic               w_up_nx, w_left_nx, w_rest_nx;

    assign w_upd   = (r_cnt == c_LAST);
    assign w_step  = w_upd & ~pause;
    // A kick arriving in the update cycle itself takes effect in that update.
    assign w_pend  = r_pend | kick;
    assign w_kvel  = kick ? kick_vel : r_kvel;
    assign w_vext  = COORD_W'(r_vel);
    assign w_ysum  = {1'b0, r_y} + {1'b0, w_vext};
    assign w_ydist = r_y - c_Y_MIN;
    assign w_vdamp = r_vel >> DAMP_SHIFT;
    assign w_vinc  = {1'b0, r_vel} + c_GRAV_W;
    assign w_vsat  = w_vinc[VEL_W] ? {VEL_W{1'b1}} : w_vinc[VEL_W-1:0];
    assign w_xsum  = {1'b0, r_x} + {1'b0, c_VX};
    assign w_xdist = r_x - c_X_MIN;
    assign w_xmove = ~r_rest | w_pend;

    always_comb begin
        w_y_nx    = r_y;
        w_v_nx    = r_vel;
        w_up_nx   = r_up;
        w_rest_nx = r_rest;
        w_vhit    = 1'b0;
        if (w_pend) begin
            w_v_nx    = w_kvel;
            w_up_nx   = 1'b1;
            w_rest_nx = 1'b0;
        end else if (!r_rest) begin
            if (!r_up) begin
                if (w_ysum >= c_YFLR_W) begin
                    w_y_nx = c_Y_FLOOR;
                    w_v_nx = w_vdamp;
                    w_vhit = 1'b1;
                    if (w_vdamp == '0) begin
                        w_rest_nx = 1'b1;
                        w_up_nx   = 1'b0;
                    end else begin
                        w_up_nx   = 1'b1;
                    end
                end else begin
                    w_y_nx = w_ysum[COORD_W-1:0];
                    w_v_nx = w_vsat;
                end
            end else if (r_vel == '0) begin
                w_up_nx = 1'b0;
                w_v_nx  = c_GRAV;
            end else if (w_ydist <= w_vext) begin
                w_y_nx  = c_Y_MIN;
                w_up_nx = 1'b0;
                w_vhit  = 1'b1;
            end else begin
                w_y_nx = r_y - w_vext;
                w_v_nx = (r_vel > c_GRAV) ? (r_vel - c_GRAV) : '0;
            end
        end
    end

    always_comb begin
        w_x_nx    = r_x;
        w_left_nx = r_left;
        w_hhit    = 1'b0;
        if (w_xmove) begin
            if (!r_left) begin
                if (w_xsum >= c_XMAX_W) begin
                    w_x_nx    = c_X_MAX;
                    w_left_nx = 1'b1;
                    w_hhit    = 1'b1;
                end else begin
                    w_x_nx = w_xsum[COORD_W-1:0];
                end
            end else if (w_xdist <= c_VX) begin
                w_x_nx    = c_X_MIN;
                w_left_nx = 1'b0;
                w_hhit    = 1'b1;
            end else begin
                w_x_nx = r_x - c_VX;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_cnt    <= '0;
            r_x      <= c_X_INIT;
            r_y      <= c_Y_INIT;
            r_vel    <= '0;
            r_up     <= 1'b0;
            r_left   <= 1'b0;
            r_rest   <= 1'b0;
            r_pend   <= 1'b0;
            r_kvel   <= '0;
            r_ft     <= 1'b0;
            r_bounce <= 1'b0;
        end else begin
            r_cnt    <= w_upd ? '0 : r_cnt + c_CNT_W'(1);
            r_ft     <= w_upd;
            r_bounce <= w_step & (w_vhit | w_hhit);
            if (w_step) begin
                r_x    <= w_x_nx;
                r_y    <= w_y_nx;
                r_vel  <= w_v_nx;
                r_up   <= w_up_nx;
                r_left <= w_left_nx;
                r_rest <= w_rest_nx;
                r_pend <= 1'b0;
            end else if (kick) begin
                r_pend <= 1'b1;
                r_kvel <= kick_vel;
            end
        end
    end

    assign center_x   = r_x;
    assign center_y   = r_y;
    assign vel_y      = r_vel;
    assign dir_up     = r_up;
    assign frame_tick = r_ft;
    assign bounce     = r_bounce;
    assign at_rest    = r_rest;

endmodule

`default_nettype wire

// File: doc/bounce_2d.md
Name: bounce_2d

Overview:
- Parametrised successor to the single-axis bouncing-ball generator.
- Drives the (center_x, center_y) position of one ball for the VGA draw stage, updated once per frame tick.
- Adds the following over the single-axis generator:
  - horizontal motion with wall reflection
  - ceiling clamp
  - configurable gravity and restitution
  - rest detection
  - a kick input that relaunches the ball.

Parameters:
- COORD_W, 11, width of center_x/center_y.
- VEL_W, 6, width of the unsigned velocity magnitudes.
- TICK_DIV, 692640, CLK cycles per update tick. Must be >= 2.
- X_MIN, 0, left wall.
- X_MAX, 1007, right wall.
- Y_MIN, 0, ceiling.
- Y_FLOOR, 500, floor.
- X_INIT, 504, reset x. Must satisfy X_MIN <= X_INIT <= X_MAX.
- Y_INIT, 0, reset y. Must satisfy Y_MIN <= Y_INIT <= Y_FLOOR.
- VX, 2, horizontal speed magnitude, in pixels per tick.
- GRAVITY, 1, vertical speed added per falling tick. Must be >= 1.
- DAMP_SHIFT, 1, speed right-shift applied on a floor hit (restitution = 2^-DAMP_SHIFT).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  reset; synchronous, active-low.
- pause  in  1  while high, position/velocity hold; the tick counter keeps running.
- kick  in  1  single-cycle launch request, accepted in any cycle.
- kick_vel  in  VEL_W  upward speed applied by the kick; sampled with kick.
- center_x  out  COORD_W  ball x.
- center_y  out  COORD_W  ball y.
- vel_y  out  VEL_W  current vertical speed magnitude.
- dir_up  out  1  1 = moving up, 0 = down.
- frame_tick  out  1  one-cycle pulse on each update cycle.
- bounce  out  1  one-cycle pulse, coincident with the position update, on a floor/ceiling/wall contact.
- at_rest  out  1  ball stopped on the floor.

Behaviour:
- Reset (RESET==0 at a CLK edge) sets:
  - counter=0, center_x=X_INIT, center_y=Y_INIT
  - vel_y=0, dir_up=0, h_dir=right
  - frame_tick=0, bounce=0, at_rest=0
  - kick pending flag=0, latched kick_vel=0.
- Reset asserted mid-flight aborts everything, including a pending kick.
- Tick counter:
  - counts 0..TICK_DIV-1 and wraps.
  - The update cycle is the cycle with counter==TICK_DIV-1.
  - frame_tick is registered high in the cycle after the update cycle.
  - The first update occurs TICK_DIV cycles after reset release.
- All outputs are registered. New state is visible the cycle after the update cycle. bounce and frame_tick are high together in that cycle. Outside update cycles, all state holds.
- Kick latch:
  - kick=1 sets pending and captures kick_vel. A later kick before the update overwrites the captured value (last wins).
  - A kick in the update cycle itself is applied in that same update.
- Update cycle with pause=1: nothing changes; pending is retained; bounce=0.
- Update cycle with pause=0 and pending=1:
  - vel_y=latched value, dir_up=1, at_rest=0, pending cleared.
  - center_y is unchanged this tick; x moves normally.
  - The kick overrides any floor/apex event in the same tick.
  - kick_vel=0 gives dir_up=1, vel_y=0, which is resolved as an apex on the next tick.
- Vertical motion, falling (dir_up=0, at_rest=0). Let s = center_y + vel_y, computed at COORD_W+1 bits:
  - If s >= Y_FLOOR: center_y=Y_FLOOR, vel_y=vel_y>>DAMP_SHIFT, dir_up=1, bounce=1. If the damped speed is 0: at_rest=1, dir_up=0.
  - Otherwise: center_y=s, vel_y=min(vel_y+GRAVITY, 2^VEL_W-1), saturating.
- Vertical motion, rising (dir_up=1):
  - If vel_y==0 (apex): dir_up=0, vel_y=GRAVITY, center_y unchanged.
  - Else if center_y-Y_MIN <= vel_y: center_y=Y_MIN, dir_up=0, vel_y unchanged, bounce=1.
  - Else: center_y -= vel_y; vel_y = vel_y>GRAVITY ? vel_y-GRAVITY : 0.
- Horizontal motion, only when at_rest=0 and pause=0:
  - Right: if center_x+VX >= X_MAX, then center_x=X_MAX, h_dir=left, bounce=1; else center_x+=VX.
  - Left: symmetric against X_MIN, with no underflow (compare center_x-X_MIN <= VX).
- Simultaneous wall and floor contact in the same tick: both handled; a single bounce pulse.
- at_rest=1: x, y and vel_y are frozen until a kick or reset.

Test Plan (TICK_DIV=4, all other parameters at default):
- Reset release, idle:
  - frame_tick pulses every 4 cycles; first pulse 4 cycles after release.
  - After n ticks, center_y=n(n-1)/2: ticks 1,2,3 give y=0,1,3.
  - center_x after n ticks = 504+2n.
- Floor hit:
  - After 32 ticks: y=496, vel_y=32.
  - Tick 33: y=500, vel_y=16, dir_up=1, bounce=1 for exactly one cycle.
- Rest:
  - Continue until a floor hit with vel_y=1: vel_y becomes 0, at_rest=1.
  - center_x/center_y then constant over 20 further ticks.
- Kick:
  - In rest state, kick=1 with kick_vel=20 mid-period.
  - Next tick: dir_up=1, vel_y=20, at_rest=0, y=500.
  - Following tick: y=480, vel_y=19.
- Kick in the update cycle coinciding with a floor hit: kick wins; vel_y=kick_vel, no damping applied.
- Walls and control inputs:
  - Drive x toward X_MAX (X_INIT=1003): x clamps to 1007, h_dir=left, bounce pulse; next tick x=1005.
  - pause=1 across 3 ticks: all outputs hold, frame_tick still pulses.
  - RESET=0 mid-flight: next cycle all outputs equal their reset values.
